// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer ahead of the sobel datapath: zero-pads an unpadded raster,
// feeds it one pixel per enable and tags which delayed results are real pixels.
module sobel_frame_ctrl #(
    parameter int IMG_W  = 480,
    parameter int IMG_H  = 360,
    parameter int DW     = 8,
    parameter int CW     = 10,
    parameter int DP_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] pix_out,
    output logic          pix_en,
    output logic          out_valid,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          busy,
    output logic          frame_done,
    output logic [1:0]    state
);

    generate
        if (CW < $clog2(IMG_W + 2) || CW < $clog2(IMG_H + 2)) begin : g_cw_chk
            $error("sobel_frame_ctrl: CW cannot hold IMG_W+1 / IMG_H+1");
        end
        if (DP_LAT < 1) begin : g_lat_chk
            $error("sobel_frame_ctrl: DP_LAT must be >= 1");
        end
    endgenerate

    localparam logic [CW-1:0] C_LAST = CW'(IMG_W + 1);
    localparam logic [CW-1:0] R_LAST = CW'(IMG_H + 1);
    localparam int            FW     = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(DP_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } st_t;

    typedef struct packed {
        logic          vld;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
    } tag_t;

    st_t           st, st_nx;
    logic [CW-1:0] r, c, r_nx, c_nx;
    logic [FW-1:0] fcnt, fcnt_nx;
    logic          border, win_real;
    tag_t          tag_in;
    tag_t [DP_LAT:1] tag_pipe;

    assign border   = (r == '0) || (r == R_LAST) || (c == '0) || (c == C_LAST);
    assign win_real = (r >= CW'(2)) && (c >= CW'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= IDLE;
            r    <= '0;
            c    <= '0;
            fcnt <= '0;
        end else begin
            st   <= st_nx;
            r    <= r_nx;
            c    <= c_nx;
            fcnt <= fcnt_nx;
        end
    end

    always_comb begin
        st_nx      = st;
        r_nx       = r;
        c_nx       = c;
        fcnt_nx    = fcnt;
        in_ready   = 1'b0;
        pix_en     = 1'b0;
        pix_out    = '0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (st)
            IDLE: begin
                if (start) begin
                    st_nx = RUN;
                    r_nx  = '0;
                    c_nx  = '0;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (border) begin
                    pix_en = 1'b1;
                end else begin
                    // Ready is offered on every body slot; a missing pixel just stalls r/c.
                    in_ready = 1'b1;
                    if (in_valid) begin
                        pix_en  = 1'b1;
                        pix_out = in_data;
                    end
                end
                if (pix_en) begin
                    if (c == C_LAST) begin
                        c_nx = '0;
                        if (r == R_LAST) begin
                            r_nx    = '0;
                            fcnt_nx = '0;
                            st_nx   = FLUSH;
                        end else begin
                            r_nx = r + CW'(1);
                        end
                    end else begin
                        c_nx = c + CW'(1);
                    end
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (fcnt == F_LAST) begin
                    st_nx = DONE;
                end else begin
                    fcnt_nx = fcnt + FW'(1);
                end
            end
            DONE: begin
                frame_done = 1'b1;
                st_nx      = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end

    // Tag travels alongside the datapath so the result and its coordinates line up.
    always_comb begin
        tag_in.vld = pix_en & win_real;
        tag_in.row = win_real ? (r - CW'(2)) : '0;
        tag_in.col = win_real ? (c - CW'(2)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[1] <= tag_in;
            for (int i = 2; i <= DP_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign out_valid = tag_pipe[DP_LAT].vld;
    assign out_row   = tag_pipe[DP_LAT].vld ? tag_pipe[DP_LAT].row : '0;
    assign out_col   = tag_pipe[DP_LAT].vld ? tag_pipe[DP_LAT].col : '0;
    assign state     = st;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 4x3 image, DP_LAT=1 and DP_LAT=3 instances.
module tb_sobel_frame_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int CW = 10;

    logic clk = 0;
    logic rst = 1;
    logic start_a = 0, start_b = 0;
    logic [7:0] in_data = 0;
    logic in_valid = 0;

    logic          a_in_ready, a_pix_en, a_out_valid, a_busy, a_frame_done;
    logic [7:0]    a_pix_out;
    logic [CW-1:0] a_out_row, a_out_col;
    logic [1:0]    a_state;
    logic          b_in_ready, b_pix_en, b_out_valid, b_busy, b_frame_done;
    logic [7:0]    b_pix_out;
    logic [CW-1:0] b_out_row, b_out_col;
    logic [1:0]    b_state;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .DW(8), .CW(CW), .DP_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .pix_out(a_pix_out), .pix_en(a_pix_en),
        .out_valid(a_out_valid), .out_row(a_out_row), .out_col(a_out_col),
        .busy(a_busy), .frame_done(a_frame_done), .state(a_state));

    sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .DW(8), .CW(CW), .DP_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .pix_out(b_pix_out), .pix_en(b_pix_en),
        .out_valid(b_out_valid), .out_row(b_out_row), .out_col(b_out_col),
        .busy(b_busy), .frame_done(b_frame_done), .state(b_state));

    logic sel = 0;
    logic          m_in_ready, m_pix_en, m_out_valid, m_frame_done;
    logic [7:0]    m_pix_out;
    logic [CW-1:0] m_out_row, m_out_col;
    logic [1:0]    m_state;
    assign m_in_ready   = sel ? b_in_ready   : a_in_ready;
    assign m_pix_en     = sel ? b_pix_en     : a_pix_en;
    assign m_out_valid  = sel ? b_out_valid  : a_out_valid;
    assign m_frame_done = sel ? b_frame_done : a_frame_done;
    assign m_pix_out    = sel ? b_pix_out    : a_pix_out;
    assign m_out_row    = sel ? b_out_row    : a_out_row;
    assign m_out_col    = sel ? b_out_col    : a_out_col;
    assign m_state      = sel ? b_state      : a_state;

    int n_vec = 0, n_err = 0;

    // Recorded per frame
    int n_en, n_ov, n_done, n_stall, n_flush, done_cyc, flush_last, en22_cyc, ov_cyc;
    logic [7:0] pix_q[$];
    int row_q[$], col_q[$];
    logic [7:0] exp_pix[$];

    function automatic void build_model();
        exp_pix.delete();
        for (int r = 0; r <= H + 1; r++)
            for (int c = 0; c <= W + 1; c++)
                if (r == 0 || r == H + 1 || c == 0 || c == W + 1) exp_pix.push_back(8'd0);
                else exp_pix.push_back(8'((r - 1) * W + (c - 1) + 1));
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic run_frame(input int stall_len, input bit extra_start, input int abort_at);
        int idx = 0, stalled = 0;
        n_en = 0; n_ov = 0; n_done = 0; n_stall = 0; n_flush = 0;
        done_cyc = -1; flush_last = -1; en22_cyc = -1; ov_cyc = -1;
        pix_q.delete(); row_q.delete(); col_q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            set_start((cyc == 0) || (extra_start && (cyc == 5 || m_state == 2'd3)));
            in_valid = !(idx == 5 && stalled < stall_len);
            if (!in_valid) stalled++;
            in_data = 8'(idx + 1);
            #1;
            if (m_pix_en) begin
                pix_q.push_back(m_pix_out);
                if (n_en == 14) en22_cyc = cyc;
                n_en++;
            end else if (m_state == 2'd1) n_stall++;
            if (m_out_valid) begin
                if (n_ov == 0) ov_cyc = cyc;
                row_q.push_back(int'(m_out_row));
                col_q.push_back(int'(m_out_col));
                n_ov++;
            end
            if (m_state == 2'd2) begin flush_last = cyc; n_flush++; end
            if (m_frame_done) begin n_done++; done_cyc = cyc; end
            if (m_in_ready && in_valid) idx++;
            if (n_done > 0 || (abort_at > 0 && n_en == abort_at)) break;
        end
        @(negedge clk);
        set_start(1'b0);
    endtask

    task automatic check_stream(input string tag);
        n_vec++;
        if (pix_q.size() !== exp_pix.size()) begin
            n_err++; $display("FAIL %s pix count: got %0d want %0d", tag, pix_q.size(), exp_pix.size());
        end else begin
            for (int i = 0; i < exp_pix.size(); i++) begin
                n_vec++;
                if (pix_q[i] !== exp_pix[i]) begin
                    n_err++; $display("FAIL %s pix[%0d]: got %0d want %0d", tag, i, pix_q[i], exp_pix[i]);
                end
            end
        end
        n_vec++;
        if (row_q.size() !== W * H) begin
            n_err++; $display("FAIL %s out_valid count: got %0d want %0d", tag, row_q.size(), W * H);
        end else begin
            for (int i = 0; i < W * H; i++) begin
                n_vec++;
                if (row_q[i] !== i / W || col_q[i] !== i % W) begin
                    n_err++;
                    $display("FAIL %s tag[%0d]: got (%0d,%0d) want (%0d,%0d)", tag, i, row_q[i], col_q[i], i / W, i % W);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({a_state, a_in_ready, a_pix_en, a_pix_out, a_out_valid, a_out_row, a_out_col, a_busy, a_frame_done} !== '0) begin
            n_err++; $display("FAIL reset outputs A: state=%0d en=%b busy=%b ov=%b", a_state, a_pix_en, a_busy, a_out_valid);
        end
        n_vec++;
        if ({b_state, b_in_ready, b_pix_en, b_pix_out, b_out_valid, b_out_row, b_out_col, b_busy, b_frame_done} !== '0) begin
            n_err++; $display("FAIL reset outputs B: state=%0d en=%b busy=%b ov=%b", b_state, b_pix_en, b_busy, b_out_valid);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_basic();
        sel = 0;
        run_frame(0, 0, 0);
        check_stream("basic");
        n_vec++;
        if (n_en !== 30) begin n_err++; $display("FAIL basic pix_en count: got %0d want 30", n_en); end
        n_vec++;
        if (n_done !== 1 || done_cyc !== 32) begin
            n_err++; $display("FAIL basic done: got n=%0d cyc=%0d want n=1 cyc=32", n_done, done_cyc);
        end
        n_vec++;
        if (n_flush !== 1 || flush_last !== done_cyc - 1) begin
            n_err++; $display("FAIL basic flush: got n=%0d last=%0d want n=1 last=%0d", n_flush, flush_last, done_cyc - 1);
        end
        n_vec++;
        if (ov_cyc !== en22_cyc + 1) begin
            n_err++; $display("FAIL basic latency: got ov=%0d en22=%0d want diff 1", ov_cyc, en22_cyc);
        end
    endtask

    task automatic test_stall();
        sel = 0;
        run_frame(3, 0, 0);
        check_stream("stall");
        n_vec++;
        if (n_stall !== 3) begin n_err++; $display("FAIL stall pix_en low cycles: got %0d want 3", n_stall); end
        n_vec++;
        if (done_cyc !== 35) begin n_err++; $display("FAIL stall done cycle: got %0d want 35", done_cyc); end
    endtask

    task automatic test_mid_reset();
        sel = 0;
        run_frame(0, 0, 13);
        rst = 1;
        #1;
        n_vec++;
        if ({a_state, a_in_ready, a_pix_en, a_pix_out, a_out_valid, a_out_row, a_out_col, a_busy, a_frame_done} !== '0) begin
            n_err++; $display("FAIL midreset outputs: state=%0d en=%b busy=%b ov=%b", a_state, a_pix_en, a_busy, a_out_valid);
        end
        n_vec++;
        if (n_done !== 0) begin n_err++; $display("FAIL midreset done pulse: got %0d want 0", n_done); end
        @(negedge clk);
        rst = 0;
        run_frame(0, 0, 0);
        check_stream("midreset");
        n_vec++;
        if (n_done !== 1 || done_cyc !== 32) begin
            n_err++; $display("FAIL midreset done: got n=%0d cyc=%0d want n=1 cyc=32", n_done, done_cyc);
        end
    endtask

    task automatic test_start_ignored();
        int extra_done = 0, bad_state = 0;
        sel = 0;
        run_frame(0, 1, 0);
        check_stream("startign");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (a_frame_done) extra_done++;
            if (a_state !== 2'd0) bad_state++;
        end
        n_vec++;
        if (n_done + extra_done !== 1 || done_cyc !== 32) begin
            n_err++; $display("FAIL startign done: got n=%0d cyc=%0d want n=1 cyc=32", n_done + extra_done, done_cyc);
        end
        n_vec++;
        if (bad_state !== 0) begin n_err++; $display("FAIL startign idle: got %0d non-idle cycles want 0", bad_state); end
    endtask

    task automatic test_dp_lat3();
        sel = 1;
        run_frame(0, 0, 0);
        check_stream("lat3");
        n_vec++;
        if (ov_cyc !== en22_cyc + 3 || en22_cyc !== 15) begin
            n_err++; $display("FAIL lat3 latency: got ov=%0d en22=%0d want ov=18 en22=15", ov_cyc, en22_cyc);
        end
        n_vec++;
        if (n_flush !== 3 || done_cyc !== 34) begin
            n_err++; $display("FAIL lat3 flush: got n=%0d done=%0d want n=3 done=34", n_flush, done_cyc);
        end
        n_vec++;
        if (a_state !== 2'd0 || a_busy !== 1'b0) begin
            n_err++; $display("FAIL lat3 other idle: got state=%0d busy=%b want 0/0", a_state, a_busy);
        end
        sel = 0;
    endtask

    initial begin
        build_model();
        test_reset();
        test_basic();
        test_stall();
        test_mid_reset();
        test_start_ignored();
        test_dp_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
